// File: rtl/game_sequencer.sv
// game_sequencer: whack-a-mole sequencer (countdown, gap, spawn, hit window, scoring).
// Define MOLE_SPEEDUP_EN to shrink the hit window by 100 ms every 5th hit (floor 300 ms).
module game_sequencer #(
  parameter int ROUNDS       = 30,
  parameter int COUNTDOWN_MS = 3000,
  parameter int GAP_MS       = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ms_tick,
  input  logic        start,
  input  logic [3:0]  difficulty,
  input  logic        hit,
  output logic        spawn,
  output logic        mole_active,
  output logic        wait_flag,
  output logic        play_flag,
  output logic        gameover_flag,
  output logic [11:0] countdown_ms,
  output logic [11:0] score,
  output logic [7:0]  misses,
  output logic [7:0]  round
);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, GAP, SPAWN, ACTIVE, GAMEOVER} state_t;
  state_t      state_q, state_d;
  logic        start_q, start_edge, done;
  logic [11:0] cd_q, cd_d, gap_q, gap_d, win_q, win_d, score_q, score_d;
  logic [7:0]  misses_q, misses_d, round_q, round_d;
  logic [1:0]  diff_q, diff_d;
  logic [11:0] base_win, win_load;
  logic [4:0]  flags_q, flags_d;
  assign start_edge = start & ~start_q;
  assign base_win   = diff_q == 2'd3 ? 12'd500 : diff_q == 2'd2 ? 12'd1000 : 12'd2000;
`ifdef MOLE_SPEEDUP_EN
  logic [2:0]  hits_q, hits_d;
  logic [11:0] red_q, red_d;
  assign win_load = (base_win >= red_q + 12'd300) ? base_win - red_q : 12'd300;
  always_comb begin
    hits_d = hits_q;
    red_d  = red_q;
    if ((state_q == IDLE || state_q == GAMEOVER) && start_edge) begin
      hits_d = 3'd0;
      red_d  = 12'd0;
    end else if (state_q == ACTIVE && hit) begin
      hits_d = hits_q == 3'd4 ? 3'd0 : hits_q + 3'd1;
      red_d  = (hits_q == 3'd4 && red_q < 12'd2000) ? red_q + 12'd100 : red_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hits_q <= 3'd0;
      red_q  <= 12'd0;
    end else begin
      hits_q <= hits_d;
      red_q  <= red_d;
    end
`else
  assign win_load = base_win;
`endif
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    gap_d    = gap_q;
    win_d    = win_q;
    score_d  = score_q;
    misses_d = misses_q;
    round_d  = round_q;
    diff_d   = diff_q;
    done     = 1'b0;
    case (state_q)
      IDLE, GAMEOVER: if (start_edge) begin
        state_d  = COUNTDOWN;
        cd_d     = 12'(COUNTDOWN_MS);
        score_d  = 12'd0;
        misses_d = 8'd0;
        round_d  = 8'd0;
        diff_d   = (difficulty == 4'd2 || difficulty == 4'd3) ? difficulty[1:0] : 2'd1;
      end
      COUNTDOWN: if (ms_tick) begin
        cd_d = cd_q - 12'd1;
        if (cd_q == 12'd1) begin
          state_d = GAP;
          gap_d   = 12'(GAP_MS);
        end
      end
      GAP: if (ms_tick) begin
        gap_d = gap_q - 12'd1;
        if (gap_q == 12'd1) state_d = SPAWN;
      end
      SPAWN: begin
        state_d = ACTIVE;
        round_d = round_q + 8'd1;
        win_d   = win_load;
      end
      ACTIVE: begin
        // a hit wins over a coinciding window expiry
        if (hit) begin
          score_d = score_q == 12'hFFF ? score_q : score_q + 12'd1;
          done    = 1'b1;
        end else if (ms_tick) begin
          win_d = win_q - 12'd1;
          if (win_q == 12'd1) begin
            misses_d = misses_q == 8'hFF ? misses_q : misses_q + 8'd1;
            done     = 1'b1;
          end
        end
        if (done) begin
          state_d = round_q == 8'(ROUNDS) ? GAMEOVER : GAP;
          gap_d   = 12'(GAP_MS);
        end
      end
      default: state_d = IDLE;
    endcase
    flags_d = {state_d == SPAWN, state_d == ACTIVE, state_d == COUNTDOWN,
               state_d == GAP || state_d == SPAWN || state_d == ACTIVE, state_d == GAMEOVER};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      cd_q     <= 12'd0;
      gap_q    <= 12'd0;
      win_q    <= 12'd0;
      score_q  <= 12'd0;
      misses_q <= 8'd0;
      round_q  <= 8'd0;
      diff_q   <= 2'd1;
      flags_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      cd_q     <= cd_d;
      gap_q    <= gap_d;
      win_q    <= win_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      round_q  <= round_d;
      diff_q   <= diff_d;
      flags_q  <= flags_d;
    end
  assign {spawn, mole_active, wait_flag, play_flag, gameover_flag} = flags_q;
  assign countdown_ms = cd_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign round        = round_q;
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter ROUNDS, default 30, number of moles per game (1..255).
REQ-002 Parameter COUNTDOWN_MS, default 3000, pre-game countdown length in ms (1..4095).
REQ-003 Parameter GAP_MS, default 250, idle ms between mole despawn and next spawn (1..4095).
REQ-004 Port clk  input  1  system clock (50 MHz).
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port ms_tick  input  1  one-cycle pulse per millisecond.
REQ-007 Port start  input  1  debounced, synchronised play request (level); rising edge acts.
REQ-008 Port difficulty  input  4  1=easy, 2=medium, 3=hard; any other value treated as 1.
REQ-009 Port hit  input  1  one-cycle pulse from hammer logic.
REQ-010 Port spawn  output  1  one-cycle pulse requesting a new random mole.
REQ-011 Port mole_active  output  1  high while a mole is hittable.
REQ-012 Port wait_flag / play_flag / gameover_flag  output  1 each  high in COUNTDOWN / GAP,SPAWN,ACTIVE / GAMEOVER.
REQ-013 Port countdown_ms  output  12  remaining countdown ms.
REQ-014 Port score, misses  output  12, 8  hits and expired moles this game.
REQ-015 Port round  output  8  moles spawned this game.

Function
REQ-016 States IDLE, COUNTDOWN, GAP, SPAWN, ACTIVE, GAMEOVER; exactly one active.
REQ-017 IDLE or GAMEOVER + start rising edge -> COUNTDOWN; countdown_ms=COUNTDOWN_MS, score/misses/round=0, difficulty latched; start edges elsewhere ignored.
REQ-018 COUNTDOWN: countdown_ms decrements on each ms_tick; edge with ms_tick=1 and countdown_ms=1 -> GAP, countdown_ms=0.
REQ-019 GAP: after GAP_MS ms_ticks -> SPAWN.
REQ-020 SPAWN: exactly one cycle; spawn=1, round increments, window counter loads window -> ACTIVE.
REQ-021 Window: 2000 ms (difficulty 1), 1000 ms (2), 500 ms (3), from latched value.
REQ-022 ACTIVE: mole_active=1; window counter decrements per ms_tick.
REQ-023 ACTIVE + hit: score+1 (saturate at 4095); next state GAMEOVER if round=ROUNDS else GAP.
REQ-024 ACTIVE + ms_tick with window counter=1 and no hit: misses+1 (saturate 255); same next-state rule.
REQ-025 Hit and window expiry in the same cycle: counted as hit only.
REQ-026 hit outside ACTIVE ignored; at most one score increment per mole.
REQ-027 GAMEOVER holds score, misses, round until next start edge.
REQ-028 Outputs registered; flags change on the clock edge of the state transition.

Reset
REQ-029 rst_n low asynchronously forces IDLE; all outputs 0, counters 0, latched difficulty 1.
REQ-030 Reset mid-game aborts without spawn or score pulse; first start edge after release begins a new game.

Configuration
REQ-031 Macro MOLE_SPEEDUP_EN defined: every 5th cumulative hit reduces window by 100 ms, floor 300 ms, until next game start.
REQ-032 MOLE_SPEEDUP_EN undefined: window fixed per REQ-021; no speedup logic synthesised.

Verification
REQ-033 Reset, start edge, COUNTDOWN_MS=3 -> wait_flag 3 ticks, countdown_ms 3,2,1,0, then GAP.
REQ-034 difficulty=3, hit 200 ms after spawn -> score=1, misses=0, mole_active drops next edge.
REQ-035 difficulty=2, no hit -> mole_active high exactly 1000 ms_ticks, misses=1.
REQ-036 hit coincident with final window tick -> score+1, misses unchanged.
REQ-037 ROUNDS=3, all hit -> after third hit gameover_flag=1, score=3, round=3; start edge restarts with zeros.
REQ-038 rst_n low during ACTIVE -> immediate IDLE, all outputs 0; with MOLE_SPEEDUP_EN, difficulty=1, 10 hits -> 11th window 1800 ms.
